serial_link_mon: RTL and testbench

- Sits directly downstream of the double-sampled serial receiver.
- Consumes the receiver's frame strobe, 64-bit frame word and 8-bit wrapping error count.
- Checks the per-frame sequence field, runs a link-state machine (DOWN/ACQUIRE/UP) with a watchdog, and delivers only in-sequence payload.
- Keeps saturating statistics counters for register readout.

---
 rtl/serial_link_mon.sv | 111 +++++++++++
 tb/tb_serial_link_mon.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_link_mon.sv
// serial_link_mon: sequence-checked link state machine with watchdog, in-order payload delivery and saturating stats.
module serial_link_mon #(
  parameter int SEQ_W    = 8,
  parameter int UP_COUNT = 4,
  parameter int WD_W     = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sync,
  input  logic [63:0]         d,
  input  logic [7:0]          errors,
  input  logic                clear_stats,
  output logic                link_up,
  output logic                valid,
  output logic [63-SEQ_W:0]   payload,
  output logic [15:0]         seq_err_cnt,
  output logic [15:0]         drop_cnt,
  output logic [7:0]          down_cnt
);
  typedef enum logic [1:0] {DOWN, ACQ, UP} state_t;
  localparam logic [3:0] UPC = 4'(UP_COUNT);
  state_t state_q, state_d;
  logic [SEQ_W-1:0] exp_seq_q, exp_seq_d, seq, seq_nx;
  logic [3:0] good_q, good_d;
  logic miss_q, miss_d, valid_q, valid_d, link_up_q, link_up_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0] errors_prev_q, delta, down_q, down_d;
  logic [63-SEQ_W:0] payload_q, payload_d;
  logic [15:0] seq_err_q, seq_err_d, drop_q, drop_d;
  logic [16:0] drop_sum;
  logic expire, match, seq_inc, down_inc;
  always_comb begin
    seq = d[63 -: SEQ_W];
    seq_nx = seq + 1'b1;
    match = seq == exp_seq_q;
    expire = !sync && (wd_q == '1);
    wd_d = (sync || expire) ? '0 : wd_q + 1'b1;
    state_d = state_q;
    exp_seq_d = sync ? seq_nx : exp_seq_q;
    good_d = good_q;
    miss_d = miss_q;
    valid_d = 1'b0;
    payload_d = payload_q;
    seq_inc = 1'b0;
    down_inc = 1'b0;
    case (state_q)
      DOWN: if (sync) begin
        good_d = 4'd1;
        miss_d = 1'b0;
        state_d = (UPC == 4'd1) ? UP : ACQ;
      end
      ACQ: if (sync) begin
        good_d = match ? good_q + 4'd1 : 4'd1;
        miss_d = 1'b0;
        state_d = (match && (good_q + 4'd1 == UPC)) ? UP : ACQ;
      end else if (expire) state_d = DOWN;
      default: if (sync) begin
        valid_d = match;
        payload_d = match ? d[63-SEQ_W:0] : payload_q;
        miss_d = !match;
        seq_inc = !match;
        down_inc = !match && miss_q;
        good_d = (!match && miss_q) ? 4'd1 : good_q;
        state_d = (!match && miss_q) ? ACQ : UP;
      end else if (expire) begin
        state_d = DOWN;
        down_inc = 1'b1;
      end
    endcase
    link_up_d = state_q == UP;
    delta = errors - errors_prev_q;
    drop_sum = {1'b0, drop_q} + {9'd0, delta};
    drop_d = clear_stats ? '0 : drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    seq_err_d = clear_stats ? '0 : (seq_inc && seq_err_q != 16'hFFFF) ? seq_err_q + 1'b1 : seq_err_q;
    down_d = clear_stats ? '0 : (down_inc && down_q != 8'hFF) ? down_q + 1'b1 : down_q;
  end
  always_ff @(posedge clk) begin
    errors_prev_q <= errors;
    if (rst) begin
      state_q <= DOWN;
      exp_seq_q <= '0;
      good_q <= '0;
      miss_q <= 1'b0;
      wd_q <= '0;
      valid_q <= 1'b0;
      link_up_q <= 1'b0;
      payload_q <= '0;
      seq_err_q <= '0;
      drop_q <= '0;
      down_q <= '0;
    end else begin
      state_q <= state_d;
      exp_seq_q <= exp_seq_d;
      good_q <= good_d;
      miss_q <= miss_d;
      wd_q <= wd_d;
      valid_q <= valid_d;
      link_up_q <= link_up_d;
      payload_q <= payload_d;
      seq_err_q <= seq_err_d;
      drop_q <= drop_d;
      down_q <= down_d;
    end
  end
  assign link_up = link_up_q;
  assign valid = valid_q;
  assign payload = payload_q;
  assign seq_err_cnt = seq_err_q;
  assign drop_cnt = drop_q;
  assign down_cnt = down_q;
endmodule

// File: tb/tb_serial_link_mon.sv
// tb_serial_link_mon: directed scenario tests for serial_link_mon with a 4-bit watchdog.
module tb_serial_link_mon;
  logic clk = 1'b0, rst = 1'b0, sync = 1'b0, clear_stats = 1'b0;
  logic [63:0] d = '0;
  logic [7:0] errors = '0;
  logic link_up, valid;
  logic [55:0] payload;
  logic [15:0] seq_err_cnt, drop_cnt;
  logic [7:0] down_cnt;
  int pass = 0, total = 0;
  serial_link_mon #(.SEQ_W(8), .UP_COUNT(4), .WD_W(4)) dut (
    .clk(clk), .rst(rst), .sync(sync), .d(d), .errors(errors), .clear_stats(clear_stats),
    .link_up(link_up), .valid(valid), .payload(payload), .seq_err_cnt(seq_err_cnt),
    .drop_cnt(drop_cnt), .down_cnt(down_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [55:0] pl(input logic [7:0] s);
    return {48'hA5C3_0F00_1234, s};
  endfunction
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] s);
    sync = 1'b1;
    d = {s, pl(s)};
    tick();
    sync = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic bring_up(input logic [7:0] s);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(s + 8'(i));
      tick(3);
    end
  endtask
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else pass++;
  endtask
  task automatic test_reset();
    errors = 8'd77;
    do_reset();
    chk("reset_link_up", {63'd0, link_up}, 64'd0);
    chk("reset_valid", {63'd0, valid}, 64'd0);
    chk("reset_payload", {8'd0, payload}, 64'd0);
    chk("reset_drop", {48'd0, drop_cnt}, 64'd0);
    chk("reset_counts", {40'd0, seq_err_cnt, down_cnt}, 64'd0);
  endtask
  task automatic test_acquire();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(8'(5 + i));
      chk("acq_no_valid", {63'd0, valid}, 64'd0);
      if (i < 3) tick(7);
    end
    chk("acq_link_before", {63'd0, link_up}, 64'd0);
    tick();
    chk("acq_link_after", {63'd0, link_up}, 64'd1);
    tick(6);
    send(8'd9);
    chk("acq_first_valid", {63'd0, valid}, 64'd1);
    chk("acq_first_payload", {8'd0, payload}, {8'd0, pl(8'd9)});
    tick();
    chk("acq_valid_pulse", {63'd0, valid}, 64'd0);
    chk("acq_payload_held", {8'd0, payload}, {8'd0, pl(8'd9)});
  endtask
  task automatic test_wrap();
    logic [7:0] s;
    bring_up(8'd250);
    for (int i = 0; i < 4; i++) begin
      s = 8'(254 + i);
      send(s);
      chk("wrap_valid", {63'd0, valid}, 64'd1);
      chk("wrap_payload", {8'd0, payload}, {8'd0, pl(s)});
    end
    chk("wrap_seq_err", {48'd0, seq_err_cnt}, 64'd0);
  endtask
  task automatic test_miss();
    bring_up(8'd6);
    send(8'd10);
    chk("miss_ok_valid", {63'd0, valid}, 64'd1);
    send(8'd12);
    chk("miss_single_valid", {63'd0, valid}, 64'd0);
    chk("miss_single_cnt", {48'd0, seq_err_cnt}, 64'd1);
    send(8'd13);
    chk("miss_resume_valid", {63'd0, valid}, 64'd1);
    chk("miss_resume_link", {63'd0, link_up}, 64'd1);
    send(8'd20);
    send(8'd30);
    chk("miss_double_cnt", {48'd0, seq_err_cnt}, 64'd3);
    chk("miss_double_down", {56'd0, down_cnt}, 64'd1);
    tick();
    chk("miss_double_link", {63'd0, link_up}, 64'd0);
    send(8'd31);
    send(8'd32);
    chk("miss_acq_no_valid", {63'd0, valid}, 64'd0);
    tick();
    chk("miss_acq_link", {63'd0, link_up}, 64'd0);
    send(8'd33);
    tick();
    chk("miss_reacq_link", {63'd0, link_up}, 64'd1);
  endtask
  task automatic test_watchdog();
    bring_up(8'd40);
    send(8'd44);
    tick(15);
    chk("wd_edge_link", {63'd0, link_up}, 64'd1);
    tick();
    chk("wd_expire_down_cnt", {56'd0, down_cnt}, 64'd1);
    tick();
    chk("wd_expire_link", {63'd0, link_up}, 64'd0);
    bring_up(8'd40);
    send(8'd44);
    tick(15);
    send(8'd45);
    chk("wd_save_valid", {63'd0, valid}, 64'd1);
    tick(3);
    chk("wd_save_link", {63'd0, link_up}, 64'd1);
    chk("wd_save_down_cnt", {56'd0, down_cnt}, 64'd0);
  endtask
  task automatic test_drop();
    errors = 8'd250;
    do_reset();
    chk("drop_after_reset", {48'd0, drop_cnt}, 64'd0);
    errors = 8'd3;
    tick();
    chk("drop_wrap_delta", {48'd0, drop_cnt}, 64'd9);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    for (int i = 0; i < 273; i++) begin
      errors = errors + 8'd240;
      tick();
    end
    chk("drop_fff0", {48'd0, drop_cnt}, 64'hFFF0);
    errors = errors + 8'd100;
    tick();
    chk("drop_saturate", {48'd0, drop_cnt}, 64'hFFFF);
    errors = errors + 8'd5;
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("drop_clear", {48'd0, drop_cnt}, 64'd0);
    tick();
    chk("drop_clear_discard", {48'd0, drop_cnt}, 64'd0);
  endtask
  task automatic test_reset_mid();
    bring_up(8'd60);
    send(8'd99);
    errors = errors + 8'd7;
    tick();
    chk("mid_pre_seq_err", {48'd0, seq_err_cnt}, 64'd1);
    chk("mid_pre_drop", {48'd0, drop_cnt}, 64'd7);
    rst = 1'b1;
    send(8'd100);
    rst = 1'b0;
    chk("mid_valid", {63'd0, valid}, 64'd0);
    chk("mid_link", {63'd0, link_up}, 64'd0);
    chk("mid_counts", {24'd0, seq_err_cnt, drop_cnt, down_cnt}, 64'd0);
    chk("mid_payload", {8'd0, payload}, 64'd0);
  endtask
  initial begin
    test_reset();
    test_acquire();
    test_wrap();
    test_miss();
    test_watchdog();
    test_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
